// File: rtl/uart_pkg.sv
// Shared types and frame constants for the byte-wide UART transmitter.
// Defining UART_TX_PARITY_EN adds a PARITY state and one bit per frame.
package uart_pkg;

    localparam int UART_DATA_W = 8;
    localparam int FRAME_BITS_NO_PARITY = 10;
    localparam int FRAME_BITS_PARITY = 11;

`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = FRAME_BITS_PARITY;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } uart_state_e;
`else
    localparam int FRAME_BITS = FRAME_BITS_NO_PARITY;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } uart_state_e;
`endif

    function automatic logic even_parity(
        input logic [UART_DATA_W-1:0] d
    );
        return ^d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: strobes on the last clock of each bit and
// restarts from zero whenever clr is high.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST =
        CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_byte.sv
// Byte UART transmitter: 8N1 frames, LSB first, registered tx line.
// Defining UART_TX_PARITY_EN inserts a parity bit (sense: PARITY_ODD).
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208,
    parameter int PARITY_ODD   = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [UART_DATA_W-1:0] tx_data,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    output logic                   tx,
    output logic                   tx_busy,
    output logic                   tx_done
);

    uart_state_e            state_q;
    uart_state_e            state_d;
    logic [UART_DATA_W-1:0] shreg_q;
    logic [UART_DATA_W-1:0] shreg_d;
    logic [2:0]             idx_q;
    logic [2:0]             idx_d;
    logic                   tx_q;
    logic                   tx_d;
    logic                   bit_end;
    logic                   baud_clr;
    logic                   accept;

`ifdef UART_TX_PARITY_EN
    localparam logic PAR_INV = (PARITY_ODD != 0);

    logic par_q;
    logic par_d;
`else
    logic unused_parity_cfg;
    assign unused_parity_cfg = (PARITY_ODD != 0);
`endif

    assign baud_clr = (state_q == S_IDLE);
    assign accept   = tx_valid && !rst
                   && (state_q == S_IDLE);
    assign tx       = tx_q;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clr  (baud_clr),
        .tick (bit_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next state and datapath; the shift register exposes D(idx) at bit 0.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_START;
                    shreg_d = tx_data;
                    idx_d   = '0;
`ifdef UART_TX_PARITY_EN
                    par_d = even_parity(tx_data)
                          ^ PAR_INV;
`endif
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shreg_d = shreg_q >> 1;
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs; tx_d looks at the next state so the line changes with it.
    always_comb begin
        tx_ready = (state_q == S_IDLE) && !rst;
        tx_busy  = (state_q != S_IDLE) && !rst;
        tx_done  = (state_q == S_STOP) && bit_end
                && !rst;
        tx_d     = 1'b1;
        unique case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = par_q;
`endif
            default: tx_d = 1'b1;
        endcase
    end

endmodule
